// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD frame-buffer read scheduler.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_WAIT_ROOM,
        ST_REQ,
        ST_BUSY
    } rd_state_e;

    localparam int unsigned BANK0_BASE = 0;
    localparam int          RD_LEN_W   = 8;
    localparam int          REMAIN_W   = 22;

    // Burst length is the smaller of the configured maximum and what is left of the frame.
    function automatic logic [RD_LEN_W-1:0] burst_len_of(input logic [REMAIN_W-1:0] remaining,
                                                         input int unsigned         max_len);
        if (32'(remaining) < max_len)
            return remaining[RD_LEN_W-1:0];
        else
            return RD_LEN_W'(max_len);
    endfunction

endpackage

// File: rtl/lcd_edge_det.sv
// Rising-edge detector for a level that is already synchronous to sys_clk.
module lcd_edge_det (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic sig,
    output logic rise
);

    logic sig_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            sig_q <= 1'b0;
        else
            sig_q <= sig;
    end

    assign rise = sig & ~sig_q;

endmodule

// File: rtl/lcd_rd_sched.sv
// LCD frame-buffer read scheduler: issues bursts into the line FIFO once per frame.
// Optional double-buffer bank swapping is enabled by defining LCD_RD_BANK_SWAP_EN.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   IDLE       | frame fully requested, waiting for vsync
//   FLUSH      | one-cycle FIFO clear, load frame size and reset offset
//   WAIT_ROOM  | waiting for FIFO room for a full burst (or frame end)
//   REQ        | rd_req held with stable address/length until rd_ack
//   BUSY       | burst accepted, waiting for rd_done
module lcd_rd_sched
    import lcd_pkg::*;
#(
    parameter int                 ADDR_W     = 28,
    parameter int                 BURST_LEN  = 64,
    parameter int                 FIFO_DEPTH = 512,
    parameter logic [ADDR_W-1:0]  BANK1_BASE = 28'h0100000
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                lcd_vsync,
    input  logic [10:0]         h_disp,
    input  logic [10:0]         v_disp,
    input  logic [9:0]          fifo_used,
    output logic                fifo_flush,
    output logic                rd_req,
    output logic [ADDR_W-1:0]   rd_addr,
    output logic [RD_LEN_W-1:0] rd_len,
    input  logic                rd_ack,
    input  logic                rd_done,
    input  logic                wr_frame_done,
    output logic                rd_bank,
    output logic                frame_err
);

    rd_state_e             state, state_nxt;
    logic                  fs;
    logic                  fs_pend;
    logic [REMAIN_W-1:0]   remaining;
    logic [ADDR_W-1:0]     offset;
    logic [ADDR_W-1:0]     bank_base;
    logic                  room_ok;
    logic                  flush_entry;

    lcd_edge_det u_vsync_edge (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .sig       (lcd_vsync),
        .rise      (fs)
    );

    // Widened so a FIFO reporting more than FIFO_DEPTH cannot wrap into "room".
    assign room_ok = (32'(FIFO_DEPTH) >= (32'(fifo_used) + 32'(BURST_LEN)));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:      if (fs) state_nxt = ST_FLUSH;
            ST_FLUSH:     state_nxt = fs ? ST_FLUSH : ST_WAIT_ROOM;
            ST_WAIT_ROOM: begin
                if (fs)
                    state_nxt = ST_FLUSH;
                else if (remaining == '0)
                    state_nxt = ST_IDLE;
                else if (room_ok)
                    state_nxt = ST_REQ;
            end
            ST_REQ:       if (rd_ack) state_nxt = ST_BUSY;
            ST_BUSY:      if (rd_done) state_nxt = (fs_pend || fs) ? ST_FLUSH : ST_WAIT_ROOM;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    assign flush_entry = (state_nxt == ST_FLUSH) && (state != ST_FLUSH);
    assign fifo_flush  = (state == ST_FLUSH);
    assign rd_req      = (state == ST_REQ);
    assign bank_base   = rd_bank ? BANK1_BASE : ADDR_W'(BANK0_BASE);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            remaining <= '0;
            offset    <= '0;
            rd_addr   <= '0;
            rd_len    <= '0;
            fs_pend   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= fs && (remaining != '0);
            if (state == ST_FLUSH) begin
                remaining <= REMAIN_W'(h_disp) * REMAIN_W'(v_disp);
                offset    <= '0;
                fs_pend   <= 1'b0;
            end
            if ((state == ST_REQ || state == ST_BUSY) && fs)
                fs_pend <= 1'b1;
            if (state == ST_WAIT_ROOM && state_nxt == ST_REQ) begin
                rd_addr <= bank_base + offset;
                rd_len  <= burst_len_of(remaining, BURST_LEN);
            end
            // Accounting happens on acceptance so WAIT_ROOM sees the post-burst remainder.
            if (state == ST_REQ && rd_ack) begin
                offset    <= offset + ADDR_W'(rd_len);
                remaining <= remaining - REMAIN_W'(rd_len);
            end
        end
    end

`ifdef LCD_RD_BANK_SWAP_EN
    logic swap_pend;
    logic bank_q;

    // A writer completion arriving on the flush-entry edge is kept for the next frame.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            swap_pend <= 1'b0;
            bank_q    <= 1'b0;
        end else if (flush_entry) begin
            if (swap_pend)
                bank_q <= ~bank_q;
            swap_pend <= wr_frame_done;
        end else if (wr_frame_done) begin
            swap_pend <= 1'b1;
        end
    end

    assign rd_bank = bank_q;
`else
    logic wr_frame_done_unused;
    logic flush_entry_unused;

    assign wr_frame_done_unused = wr_frame_done;
    assign flush_entry_unused   = flush_entry;
    assign rd_bank              = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_rd_sched.sv
// Directed self-checking bench for lcd_rd_sched (default parameters).
module tb_lcd_rd_sched;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        lcd_vsync = 1'b0;
    logic [10:0] h_disp = '0;
    logic [10:0] v_disp = '0;
    logic [9:0]  fifo_used = '0;
    logic        fifo_flush;
    logic        rd_req;
    logic [27:0] rd_addr;
    logic [7:0]  rd_len;
    logic        rd_ack = 1'b0;
    logic        rd_done = 1'b0;
    logic        wr_frame_done = 1'b0;
    logic        rd_bank;
    logic        frame_err;

    int n_pass = 0;
    int n_total = 0;
    int err_pulses = 0;

    lcd_rd_sched dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .lcd_vsync     (lcd_vsync),
        .h_disp        (h_disp),
        .v_disp        (v_disp),
        .fifo_used     (fifo_used),
        .fifo_flush    (fifo_flush),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_len        (rd_len),
        .rd_ack        (rd_ack),
        .rd_done       (rd_done),
        .wr_frame_done (wr_frame_done),
        .rd_bank       (rd_bank),
        .frame_err     (frame_err)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) if (frame_err === 1'b1) err_pulses++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic frame_start();
        lcd_vsync = 1'b1;
        tick();
        lcd_vsync = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, " rd_req"},     32'(rd_req),     32'd0);
        check({pfx, " rd_addr"},    32'(rd_addr),    32'd0);
        check({pfx, " rd_len"},     32'(rd_len),     32'd0);
        check({pfx, " fifo_flush"}, 32'(fifo_flush), 32'd0);
        check({pfx, " frame_err"},  32'(frame_err),  32'd0);
        check({pfx, " rd_bank"},    32'(rd_bank),    32'd0);
    endtask

    initial begin
        int flushes;
        int reqs;

        // Reset values
        #3;
        check_reset_outputs("rst");
        #4 sys_rst_n = 1'b1;
        tick();

        // 8x10 frame, empty FIFO: bursts (0,64) then (64,16)
        h_disp = 11'd8;
        v_disp = 11'd10;
        fifo_used = 10'd0;
        frame_start();
        check("A flush pulse", 32'(fifo_flush), 32'd1);
        check("A no err", 32'(frame_err), 32'd0);
        tick();
        check("A flush one cycle", 32'(fifo_flush), 32'd0);
        check("A no req in flush+1", 32'(rd_req), 32'd0);
        tick();
        check("A b0 req", 32'(rd_req), 32'd1);
        check("A b0 addr", 32'(rd_addr), 32'h0);
        check("A b0 len", 32'(rd_len), 32'd64);
        tick(2);
        check("A b0 req held", 32'(rd_req), 32'd1);
        check("A b0 addr held", 32'(rd_addr), 32'h0);
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        check("A busy req low", 32'(rd_req), 32'd0);
        tick(2);
        check("A busy waits done", 32'(rd_req), 32'd0);
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        check("A wait_room req low", 32'(rd_req), 32'd0);
        tick();
        check("A b1 req", 32'(rd_req), 32'd1);
        check("A b1 addr", 32'(rd_addr), 32'd64);
        check("A b1 len", 32'(rd_len), 32'd16);
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        tick(4);
        check("A idle no req", 32'(rd_req), 32'd0);
        check("A no err pulses", 32'(err_pulses), 32'd0);

        // FIFO room threshold: 460 used blocks, 448 used allows
        fifo_used = 10'd460;
        frame_start();
        check("B no err at fs", 32'(frame_err), 32'd0);
        tick(2);
        check("B blocked 460", 32'(rd_req), 32'd0);
        tick(4);
        check("B still blocked", 32'(rd_req), 32'd0);
        fifo_used = 10'd448;
        tick();
        check("B req at 448", 32'(rd_req), 32'd1);
        check("B addr", 32'(rd_addr), 32'h0);
        check("B len", 32'(rd_len), 32'd64);
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;

        // Frame start during BUSY with 16 words outstanding
        lcd_vsync = 1'b1;
        tick();
        lcd_vsync = 1'b0;
        check("C err pulse", 32'(frame_err), 32'd1);
        tick();
        check("C err one cycle", 32'(frame_err), 32'd0);
        check("C no early flush", 32'(fifo_flush), 32'd0);
        tick(2);
        check("C flush waits done", 32'(fifo_flush), 32'd0);
        check("C no req in busy", 32'(rd_req), 32'd0);
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        check("C flush after done", 32'(fifo_flush), 32'd1);
        tick();
        check("C flush ends", 32'(fifo_flush), 32'd0);
        tick();
        check("C new req", 32'(rd_req), 32'd1);
        check("C new addr", 32'(rd_addr), 32'h0);
        check("C new len", 32'(rd_len), 32'd64);
        check("C err pulse count", 32'(err_pulses), 32'd1);

        // Asynchronous reset while in REQ
        #2 sys_rst_n = 1'b0;
        #1;
        check_reset_outputs("D async");
        #2 sys_rst_n = 1'b1;
        tick(3);
        check("D stays idle", 32'(rd_req), 32'd0);

        // Zero-width frame: one flush, no request
        h_disp = 11'd0;
        v_disp = 11'd10;
        fifo_used = 10'd0;
        frame_start();
        flushes = int'(fifo_flush);
        reqs = int'(rd_req);
        for (int i = 0; i < 6; i++) begin
            tick();
            flushes += int'(fifo_flush);
            reqs += int'(rd_req);
        end
        check("E flush count", 32'(flushes), 32'd1);
        check("E req count", 32'(reqs), 32'd0);

        // Writer completion before frame start
        h_disp = 11'd8;
        v_disp = 11'd10;
        wr_frame_done = 1'b1;
        tick();
        wr_frame_done = 1'b0;
        tick();
        frame_start();
        tick(2);
        check("F req", 32'(rd_req), 32'd1);
        check("F len", 32'(rd_len), 32'd64);
`ifdef LCD_RD_BANK_SWAP_EN
        check("F bank swapped", 32'(rd_bank), 32'd1);
        check("F bank1 addr", 32'(rd_addr), 32'h0100000);
`else
        check("F bank fixed", 32'(rd_bank), 32'd0);
        check("F bank0 addr", 32'(rd_addr), 32'h0);
`endif
        check("F err pulse count", 32'(err_pulses), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
